store_rmw_ctrl: RTL and testbench
=================================

// Module: store_rmw_ctrl
// PURPOSE
//  Sequences memory loads and stores for the multicycle CPU, including the read-modify-write needed for sb/sh.
//  For sub-word stores it reads the target word into an internal MDR and drives the store-size merge unit.
//  It then writes the merged word back, so the control FSM issues one request and waits for done.
//  Sits between the main control unit / register datapath and the single-port word memory.
// PARAMETERS
//  MEM_LAT  1  memory read latency in cycles (1..7); mem_rdata valid MEM_LAT cycles after address presented
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  req_valid  in   1   request strobe from control unit
//  req_ready  out  1   high when idle; request accepted on edge where req_valid & req_ready
//  req_write  in   1   1 = store, 0 = load
//  req_size   in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_addr   in   32  memory address (used as given, no alignment adjustment)
//  req_wdata  in   32  store data (register B)
//  mem_addr   out  32  memory address, held from accept until return to IDLE
//  mem_we     out  1   memory write enable
//  mem_wdata  out  32  memory write data (= merge_out)
//  mem_rdata  in   32  memory read data
//  mdr_q      out  32  MDR contents -> merge unit data input
//  b_q        out  32  latched req_wdata -> merge unit b input
//  merge_ctrl out  2   merge unit size select
//  merge_out  in   32  merged word from merge unit
//  rdata      out  32  load result (full word = MDR)
//  done       out  1   one-cycle completion pulse
//  err        out  1   valid with done; 1 = illegal size, no memory access made
// BEHAVIOUR
//  States: IDLE, RD, WR, DN. Outputs are decoded from registered state only; no input->output comb paths except mem_wdata=merge_out.
//  Reset: state=IDLE, req_ready=1, mem_we=0, done=0, err=0, mem_addr=0, mdr_q=0, b_q=0, rdata=0, merge_ctrl=2'b10.
//  Accept (IDLE, req_valid=1): latch addr, size, write, wdata into b_q.
//  Next state: size 11 -> DN with err=1. Word store -> WR. Sub-word store or any load -> RD with counter=0.
//  RD: mem_we=0, mem_addr held. Counter increments each cycle; MDR captures mem_rdata at the edge that ends the MEM_LAT-th RD cycle.
//  RD exit: RD then goes to WR (store) or DN (load). RD lasts exactly MEM_LAT cycles.
//  WR: exactly one cycle with mem_we=1, mem_wdata=merge_out, merge_ctrl=latched size. Next state DN.
//  merge_ctrl outside WR = 2'b10.
//  DN: done=1 for one cycle; err valid; rdata=MDR for loads. Next state IDLE.
//  Byte/half stores leave bits [31:8]/[31:16] of the stored word as read.
//  Latency, accept edge to done high: word store 2 cycles; sub-word store MEM_LAT+2; load MEM_LAT+1; illegal 1.
//  req_ready=0 in RD/WR/DN; req_valid ignored while busy and not queued.
//  Back-to-back throughput: new request can be accepted on the first IDLE cycle after DN.
//  Reset has priority over everything, including mid-RD or WR.
//  Reset mid-RD or WR: next cycle IDLE with mem_we=0. The interrupted write is not completed and done is not raised.
//  MDR is updated only in RD; rdata/mdr_q hold their value across requests until the next read.
// TESTING
//  MEM_LAT=1; word store addr 0x10, wdata 0xDEADBEEF -> single write cycle 0xDEADBEEF, no read, done 2 cycles after accept.
//  Mem[0x20]=0x11223344; sb wdata 0xAABBCCDD -> read, then write 0x112233DD, merge_ctrl=00 in WR, done at +3.
//  MEM_LAT=3; Mem[0x20]=0x11223344; sh wdata 0x0000BEEF -> 3 RD cycles, write 0x1122BEEF, done at +5.
//  MEM_LAT=3; load addr 0x30, Mem=0xCAFEF00D -> mem_we never high, rdata=0xCAFEF00D with done at +4.
//  size=11 store -> done & err at +1, mem_we never asserted. Next valid request accepted right after.
//  reset during RD of sb -> IDLE, no write issued, no done.
//  req_valid held high throughout: second request accepted only after DN.

Source files
------------

// File: rtl/store_rmw_ctrl.sv
// Load/store sequencer for the multicycle CPU; sub-word stores are done as
// read-modify-write through an internal MDR and the external merge unit.
module store_rmw_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr_q,
  output logic [31:0] b_q,
  output logic [1:0]  merge_ctrl,
  input  logic [31:0] merge_out,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RD, WR, DN} state_t;

  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam logic [2:0] RD_LAST = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] rd_cnt;
  logic [1:0] size_q;
  logic       write_q;

  assign mem_wdata = merge_out;

  // Outputs are registered alongside the state they belong to, so each one
  // is set on the edge that enters its state and cleared by the default.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      size_q     <= SZ_WORD;
      write_q    <= 1'b0;
      req_ready  <= 1'b1;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mdr_q      <= '0;
      b_q        <= '0;
      rdata      <= '0;
      merge_ctrl <= SZ_WORD;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      merge_ctrl <= SZ_WORD;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr  <= req_addr;
            size_q    <= req_size;
            write_q   <= req_write;
            b_q       <= req_wdata;
            rd_cnt    <= '0;
            req_ready <= 1'b0;
            if (req_size == SZ_ILL) begin
              state <= DN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (req_write && req_size == SZ_WORD) begin
              state      <= WR;
              mem_we     <= 1'b1;
              merge_ctrl <= req_size;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          rd_cnt <= rd_cnt + 3'd1;
          if (rd_cnt == RD_LAST) begin
            mdr_q <= mem_rdata;
            rdata <= mem_rdata;
            if (write_q) begin
              state      <= WR;
              mem_we     <= 1'b1;
              merge_ctrl <= size_q;
            end else begin
              state <= DN;
              done  <= 1'b1;
            end
          end
        end
        WR: begin
          state <= DN;
          done  <= 1'b1;
        end
        DN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: word memory with read latency, merge unit, and a
// transaction-level reference model of loads, stores and sub-word merges.
module tb_store_rmw_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [31:0] mdr_q, b_q, merge_out, rdata;
  logic [1:0]  merge_ctrl;
  logic        done, err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem  [0:255];
  logic [31:0] rmem [0:255];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr, pl_data;
  int          age = 0;
  logic [31:0] exp_rd;
  bit          chain;

  store_rmw_ctrl #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mdr_q(mdr_q), .b_q(b_q),
    .merge_ctrl(merge_ctrl), .merge_out(merge_out), .rdata(rdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory writes (and bench preloads) land on the rising edge.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr[9:2]] <= pl_data;
    else if (mem_we === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Read data only becomes valid in the LAT-th cycle after the address is presented.
  always @(negedge clk) begin
    if (req_ready !== 1'b0) age = -1;
    else age = age + 1;
    mem_rdata = (age >= LAT - 1) ? mem[mem_addr[9:2]] : 32'hBAD0_0BAD;
  end

  assign merge_out = (merge_ctrl == 2'b00) ? {mdr_q[31:8],  b_q[7:0]}  :
                     (merge_ctrl == 2'b01) ? {mdr_q[31:16], b_q[15:0]} : b_q;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] expv, input string tag);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic set_mem(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
    rmem[a[9:2]] = v;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    int waits, lat, nwr, exp_lat;
    bit side_bad;
    logic [31:0] waddr, wdat, old, mask, expw;
    logic [1:0] wmc;
    @(negedge clk);
    req_write = w; req_size = sz; req_addr = a; req_wdata = d; req_valid = 1'b1;
    waits = 0;
    while (req_ready !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk({31'b0, req_ready}, 32'd1, "accept_ready");
    if (chain) chk(waits, 32'd1, "accept_wait");
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    nwr = 0; side_bad = 1'b0; lat = 0;
    waddr = '0; wdat = '0; wmc = 2'b11;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      lat = k + 1;
      if (mem_we === 1'b1) begin
        nwr++; waddr = mem_addr; wdat = mem_wdata; wmc = merge_ctrl;
      end else if (merge_ctrl !== 2'b10) side_bad = 1'b1;
      if (req_ready !== 1'b0) side_bad = 1'b1;
      if (done === 1'b1) break;
    end
    old  = rmem[a[9:2]];
    mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    if (sz == 2'd3)              exp_lat = 1;
    else if (w && sz == 2'd2)    exp_lat = 2;
    else if (w)                  exp_lat = LAT + 2;
    else                         exp_lat = LAT + 1;
    if (sz != 2'd3 && !(w && sz == 2'd2)) exp_rd = old;
    chk(lat, exp_lat, "latency");
    chk({31'b0, done}, 32'd1, "done");
    chk({31'b0, err}, {31'b0, sz == 2'd3}, "err");
    chk({31'b0, side_bad}, 32'd0, "busy_outputs");
    chk(b_q, d, "b_q");
    if (w && sz != 2'd3) begin
      expw = (old & ~mask) | (d & mask);
      rmem[a[9:2]] = expw;
      chk(nwr, 32'd1, "write_count");
      chk(waddr, a, "write_addr");
      chk(wdat, expw, "write_data");
      chk({30'b0, wmc}, {30'b0, sz}, "merge_ctrl_wr");
    end else begin
      chk(nwr, 32'd0, "no_write");
    end
    chk(rdata, exp_rd, "rdata");
    chk(mdr_q, exp_rd, "mdr_q");
    chk(mem[a[9:2]], rmem[a[9:2]], "mem_contents");
    chain = 1'b1;
  endtask

  initial begin
    bit bad;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_addr = '0; req_wdata = '0; exp_rd = '0; chain = 1'b0;
    for (int i = 0; i < 80; i++) set_mem(32'(i * 4), $urandom);
    @(posedge clk); #1;
    chk({31'b0, req_ready}, 32'd1, "rst_req_ready");
    chk({31'b0, mem_we}, 32'd0, "rst_mem_we");
    chk({31'b0, done}, 32'd0, "rst_done");
    chk({31'b0, err}, 32'd0, "rst_err");
    chk(mem_addr, 32'd0, "rst_mem_addr");
    chk(mdr_q, 32'd0, "rst_mdr_q");
    chk(b_q, 32'd0, "rst_b_q");
    chk(rdata, 32'd0, "rst_rdata");
    chk({30'b0, merge_ctrl}, 32'd2, "rst_merge_ctrl");
    @(negedge clk); reset = 1'b0;

    // Directed cases
    do_req(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
    set_mem(32'h20, 32'h1122_3344);
    chain = 1'b0;
    do_req(1'b1, 2'b00, 32'h20, 32'hAABB_CCDD, 1'b0);
    chk(rmem[8], 32'h1122_33DD, "sb_result");
    set_mem(32'h20, 32'h1122_3344);
    chain = 1'b0;
    do_req(1'b1, 2'b01, 32'h20, 32'h0000_BEEF, 1'b0);
    chk(rmem[8], 32'h1122_BEEF, "sh_result");
    set_mem(32'h30, 32'hCAFE_F00D);
    chain = 1'b0;
    do_req(1'b0, 2'b10, 32'h30, 32'h0, 1'b0);
    chk(rdata, 32'hCAFE_F00D, "load_result");
    do_req(1'b1, 2'b11, 32'h50, 32'h1234_5678, 1'b1);
    do_req(1'b0, 2'b10, 32'h40, 32'h0, 1'b1);
    do_req(1'b1, 2'b00, 32'h44, 32'h0000_0077, 1'b0);

    // Reset in the middle of a sub-word store's read phase
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_addr = 32'h48; req_wdata = 32'h0000_00EE;
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk({31'b0, req_ready}, 32'd1, "midrd_rst_ready");
    chk({31'b0, mem_we}, 32'd0, "midrd_rst_we");
    chk({31'b0, done}, 32'd0, "midrd_rst_done");
    chk(mdr_q, 32'd0, "midrd_rst_mdr");
    @(negedge clk); reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (mem_we !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    chk({31'b0, bad}, 32'd0, "midrd_rst_quiet");
    chk(mem[18], rmem[18], "midrd_rst_mem");
    exp_rd = '0;
    chain = 1'b0;

    // Randomized traffic over a small address pool, back to back
    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 1)));
    end

    @(negedge clk); req_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
